// File: rtl/result_uart_serializer.sv
// result_uart_serializer: sends a captured 72-bit result as nine 8N1 UART
// frames, C00 first and LSB first within each byte. The frames go out back-to-back.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   result_in  72-bit result, C00 in [71:64] .. C22 in [7:0]
//   valid_in   one-cycle strobe marking result_in valid
//   tx         UART serial line, idles high
//   busy       transfer in progress
//   done       one-cycle pulse after the last stop bit
//   overrun    sticky: valid_in seen while busy
//
// Optional build macro RESULT_TX_CHECKSUM_EN appends a tenth frame. Its
// payload is the XOR of the nine result bytes.

module result_uart_serializer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] result_in,
    input  logic        valid_in,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef RESULT_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_BYTE = 4'd9;
`else
    localparam logic [3:0] LAST_BYTE = 4'd8;
`endif

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [71:0] hold;
    logic [3:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [CW-1:0] cnt;

    logic [7:0]  cur_byte;
    logic        bit_end;

`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0]  checksum;

    always_comb begin
        checksum = hold[71:64] ^ hold[63:56] ^ hold[55:48]
                 ^ hold[47:40] ^ hold[39:32] ^ hold[31:24]
                 ^ hold[23:16] ^ hold[15:8]  ^ hold[7:0];
    end
`endif

    // Byte 0 is the most significant byte (row-major C00 first).
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            4'd0:    cur_byte = hold[71:64];
            4'd1:    cur_byte = hold[63:56];
            4'd2:    cur_byte = hold[55:48];
            4'd3:    cur_byte = hold[47:40];
            4'd4:    cur_byte = hold[39:32];
            4'd5:    cur_byte = hold[31:24];
            4'd6:    cur_byte = hold[23:16];
            4'd7:    cur_byte = hold[15:8];
            4'd8:    cur_byte = hold[7:0];
`ifdef RESULT_TX_CHECKSUM_EN
            4'd9:    cur_byte = checksum;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    assign bit_end = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold     <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;

            // A strobe during a transfer is dropped but remembered.
            if (valid_in && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (valid_in) begin
                        hold     <= result_in;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        cnt      <= RELOAD;
                        overrun  <= 1'b0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt     <= RELOAD;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        cnt <= RELOAD;
                        if (byte_idx == LAST_BYTE) begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // Next start bit follows with no idle gap.
                            byte_idx <= byte_idx + 4'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_uart_serializer.sv
// tb_result_uart_serializer: directed table plus hand sequences for
// result_uart_serializer at CLKS_PER_BIT=4.

module tb_result_uart_serializer;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NFR = 10;
`else
    localparam int NFR = 9;
`endif

    typedef struct {
        logic [71:0] data;
        logic [7:0]  ck;
        int          ov_at;
        bit          chain;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] result_in;
    logic        valid_in;
    logic        tx;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    result_uart_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .result_in (result_in),
        .valid_in  (valid_in),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected line level t cycles after the capture edge.
    function automatic logic exp_tx(input logic [71:0] d, input logic [7:0] ck,
                                    input int t);
        int f = t / FRAME;
        int w = (t % FRAME) / CPB;
        logic [71:0] s;
        logic [7:0]  b;
        if (w == 0) return 1'b0;
        if (w == 9) return 1'b1;
        if (f < 9) begin
            s = d >> (8 * (8 - f));
            b = s[7:0];
        end else begin
            b = ck;
        end
        return b[w-1];
    endfunction

    task automatic run_xfer(input vec_t v, input bit presync, input string nm,
                            input logic [71:0] next_data);
        if (!presync) begin
            @(negedge clk);
            valid_in  = 1'b1;
            result_in = v.data;
        end
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        result_in = ~v.data;
        for (int t = 0; t < NFR * FRAME; t++) begin
            @(negedge clk);
            chk({nm, " tx"}, tx, exp_tx(v.data, v.ck, t));
            chk({nm, " busy"}, busy, 1'b1);
            chk({nm, " done_early"}, done, 1'b0);
            chk({nm, " overrun"}, overrun, v.ov_at != 0 && t > v.ov_at);
            if (v.ov_at != 0 && t == v.ov_at) begin
                valid_in  = 1'b1;
                result_in = 72'h5A_C3_3C_77_88_99_AA_BB_CC;
            end else if (v.ov_at != 0 && t == v.ov_at + 1) begin
                valid_in  = 1'b0;
                result_in = ~v.data;
            end
        end
        @(negedge clk);
        chk({nm, " done"}, done, 1'b1);
        chk({nm, " busy_end"}, busy, 1'b0);
        chk({nm, " tx_end"}, tx, 1'b1);
        chk({nm, " overrun_end"}, overrun, v.ov_at != 0);
        if (v.chain) begin
            valid_in  = 1'b1;
            result_in = next_data;
        end else begin
            @(negedge clk);
            chk({nm, " done_pulse"}, done, 1'b0);
            chk({nm, " busy_idle"}, busy, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[4];
        logic        a5[8];
        logic [71:0] nxt;

        tbl[0] = '{72'h01_02_03_04_05_06_07_08_09, 8'h01, 0, 1'b0};
        tbl[1] = '{72'hA5_00_00_00_00_00_00_00_5A, 8'hFF, 0, 1'b0};
        tbl[2] = '{72'hFF_00_FF_00_FF_00_FF_00_FF, 8'hFF, 50, 1'b1};
        tbl[3] = '{72'h12_34_56_78_9A_BC_DE_F0_0F, 8'h0F, 0, 1'b0};
        a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst       = 1'b1;
        valid_in  = 1'b0;
        result_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx", tx, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            nxt = '0;
            if (i < 3) nxt = tbl[i+1].data;
            run_xfer(tbl[i], i > 0 && tbl[i-1].chain,
                     $sformatf("vec%0d", i), nxt);
        end

        // Bit order of 8'hA5, then a reset mid-frame at E0+100.
        @(negedge clk);
        valid_in  = 1'b1;
        result_in = 72'hA5_11_22_33_44_55_66_77_88;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (t % CPB == 2 && t / CPB >= 1 && t / CPB <= 8)
                chk($sformatf("a5 bit%0d", t / CPB - 1), tx, a5[t / CPB - 1]);
            if (t == 60) chk("rst_seq overrun", overrun, 1'b1);
            if (t == 50) valid_in = 1'b1;
            if (t == 51) valid_in = 1'b0;
            if (t == 99) rst = 1'b1;
        end
        @(negedge clk);
        chk("midrst tx", tx, 1'b1);
        chk("midrst busy", busy, 1'b0);
        chk("midrst overrun", overrun, 1'b0);
        chk("midrst done", done, 1'b0);
        rst = 1'b0;
        for (int t = 0; t < 450; t++) begin
            @(negedge clk);
            chk("postrst done", done, 1'b0);
            chk("postrst tx", tx, 1'b1);
        end

        run_xfer(tbl[0], 1'b0, "after_rst", '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
